// File: rtl/cond_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_logic_unit
// Purpose  : Holds the architectural NZCV flag register, evaluates the ARM
//            condition field of each incoming instruction against it, commits
//            flag writes only for executed instructions, and gates the
//            PCS/RegW/MemW write requests into registered PCSrc/RegWrite/
//            MemWrite enables (1-cycle latency).
// Ports    : clk, rst_n (sync, active low)
//            valid_in, cond[3:0], ALUflags[3:0], flagW[1:0],
//            PCS, RegW, MemW, NoWrite                          -> inputs
//            valid_out, CondEx, PCSrc, RegWrite, MemWrite,
//            flags[3:0] {N,Z,C,V}                              -> outputs
//            exec_cnt, squash_cnt [CNT_W-1:0]  (COND_STATS_EN only)
// Options  : `define COND_STATS_EN adds saturating executed/squashed counters.
// Revision : 1.0 - initial release
// ============================================================================
module cond_logic_unit #(
    parameter int         CNT_W     = 16,
    parameter logic [3:0] FLAGS_RST = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       cond,
    input  logic [3:0]       ALUflags,
    input  logic [1:0]       flagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             valid_out,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
`ifdef COND_STATS_EN
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt,
`endif
    output logic [3:0]       flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       valid_q;
    logic       cond_ex_q;
    logic       pcsrc_q;
    logic       regwrite_q;
    logic       memwrite_q;
    logic       cond_ex_c;
    logic       exec_c;

    logic       n_flag;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;

    // Condition is judged against the committed flags, i.e. the state left
    // by the previous instruction, so back-to-back dependencies need no bubble.
    assign n_flag = flags_q[3];
    assign z_flag = flags_q[2];
    assign c_flag = flags_q[1];
    assign v_flag = flags_q[0];

    always_comb begin
        cond_ex_c = 1'b1;
        case (cond)
            4'h0:    cond_ex_c = z_flag;
            4'h1:    cond_ex_c = ~z_flag;
            4'h2:    cond_ex_c = c_flag;
            4'h3:    cond_ex_c = ~c_flag;
            4'h4:    cond_ex_c = n_flag;
            4'h5:    cond_ex_c = ~n_flag;
            4'h6:    cond_ex_c = v_flag;
            4'h7:    cond_ex_c = ~v_flag;
            4'h8:    cond_ex_c = c_flag & ~z_flag;
            4'h9:    cond_ex_c = ~c_flag | z_flag;
            4'hA:    cond_ex_c = (n_flag == v_flag);
            4'hB:    cond_ex_c = (n_flag != v_flag);
            4'hC:    cond_ex_c = ~z_flag & (n_flag == v_flag);
            4'hD:    cond_ex_c = z_flag | (n_flag != v_flag);
            default: cond_ex_c = 1'b1;
        endcase
    end

    assign exec_c = valid_in & cond_ex_c;

    // N/Z and C/V are written independently so that logical ops can update
    // N/Z while preserving the carry/overflow from an earlier arithmetic op.
    always_comb begin
        flags_d = flags_q;
        if (exec_c) begin
            if (flagW[1]) begin
                flags_d[3:2] = ALUflags[3:2];
            end
            if (flagW[0]) begin
                flags_d[1:0] = ALUflags[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= FLAGS_RST;
            valid_q    <= 1'b0;
            cond_ex_q  <= 1'b0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            valid_q    <= valid_in;
            cond_ex_q  <= exec_c;
            pcsrc_q    <= exec_c & PCS;
            regwrite_q <= exec_c & RegW & ~NoWrite;
            memwrite_q <= exec_c & MemW;
        end
    end

    assign valid_out = valid_q;
    assign CondEx    = cond_ex_q;
    assign PCSrc     = pcsrc_q;
    assign RegWrite  = regwrite_q;
    assign MemWrite  = memwrite_q;
    assign flags     = flags_q;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] squash_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else if (valid_in) begin
            if (cond_ex_c) begin
                if (exec_cnt_q != {CNT_W{1'b1}}) begin
                    exec_cnt_q <= exec_cnt_q + 1'b1;
                end
            end else begin
                if (squash_cnt_q != {CNT_W{1'b1}}) begin
                    squash_cnt_q <= squash_cnt_q + 1'b1;
                end
            end
        end
    end

    assign exec_cnt   = exec_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    // Keeps the counter width parameter referenced when statistics are absent.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_logic_unit
// Purpose  : Self-checking bench for cond_logic_unit. Directed scenarios plus
//            randomized traffic, compared against a behavioural model of the
//            ARM condition rules and NZCV commit behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [3:0] cond;
    logic [3:0] ALUflags;
    logic [1:0] flagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       valid_out;
    logic       CondEx;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] flags;

    int n_chk;
    int n_pass;

    // model state
    logic [3:0] m_flags;
    logic       e_valid;
    logic       e_condex;
    logic       e_pcsrc;
    logic       e_regw;
    logic       e_memw;

`ifdef COND_STATS_EN
    logic [15:0] exec_cnt;
    logic [15:0] squash_cnt;
    logic [1:0]  exec_cnt2;
    logic [1:0]  squash_cnt2;
    int          m_exec;
    int          m_squash;
    int          m_exec2;
    int          m_squash2;
`endif

    cond_logic_unit #(.CNT_W(16), .FLAGS_RST(4'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .cond      (cond),
        .ALUflags  (ALUflags),
        .flagW     (flagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .valid_out (valid_out),
        .CondEx    (CondEx),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
`ifdef COND_STATS_EN
        .exec_cnt  (exec_cnt),
        .squash_cnt(squash_cnt),
`endif
        .flags     (flags)
    );

`ifdef COND_STATS_EN
    logic       valid_out2;
    logic       condex2;
    logic       pcsrc2;
    logic       regw2;
    logic       memw2;
    logic [3:0] flags2;

    cond_logic_unit #(.CNT_W(2), .FLAGS_RST(4'h0)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .cond      (cond),
        .ALUflags  (ALUflags),
        .flagW     (flagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .valid_out (valid_out2),
        .CondEx    (condex2),
        .PCSrc     (pcsrc2),
        .RegWrite  (regw2),
        .MemWrite  (memw2),
        .exec_cnt  (exec_cnt2),
        .squash_cnt(squash_cnt2),
        .flags     (flags2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural condition rule: even codes test a predicate, the following
    // odd code is its negation; 0xE and 0xF always pass.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One instruction slot: drive on the falling edge, let the model predict,
    // sample just after the rising edge.
    task automatic step(input logic v, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic rw,
                        input logic mw, input logic nw);
        logic ex;
        @(negedge clk);
        valid_in = v;
        cond     = c;
        ALUflags = alu;
        flagW    = fw;
        PCS      = pcs;
        RegW     = rw;
        MemW     = mw;
        NoWrite  = nw;
        ex = cond_pass(c, m_flags);
        if (!rst_n) begin
            m_flags = 4'h0;
            {e_valid, e_condex, e_pcsrc, e_regw, e_memw} = 5'b0;
`ifdef COND_STATS_EN
            m_exec = 0; m_squash = 0; m_exec2 = 0; m_squash2 = 0;
`endif
        end else begin
            e_valid  = v;
            e_condex = v && ex;
            e_pcsrc  = v && ex && pcs;
            e_regw   = v && ex && rw && !nw;
            e_memw   = v && ex && mw;
            if (v && ex) begin
                if (fw[1]) m_flags[3:2] = alu[3:2];
                if (fw[0]) m_flags[1:0] = alu[1:0];
            end
`ifdef COND_STATS_EN
            if (v) begin
                if (ex) begin
                    if (m_exec < 65535) m_exec++;
                    if (m_exec2 < 3) m_exec2++;
                end else begin
                    if (m_squash < 65535) m_squash++;
                    if (m_squash2 < 3) m_squash2++;
                end
            end
`endif
        end
        @(posedge clk);
        #1;
        chk("valid_out", 16'(valid_out), 16'(e_valid));
        chk("CondEx",    16'(CondEx),    16'(e_condex));
        chk("PCSrc",     16'(PCSrc),     16'(e_pcsrc));
        chk("RegWrite",  16'(RegWrite),  16'(e_regw));
        chk("MemWrite",  16'(MemWrite),  16'(e_memw));
        chk("flags",     16'(flags),     16'(m_flags));
`ifdef COND_STATS_EN
        chk("exec_cnt",    exec_cnt,           16'(m_exec));
        chk("squash_cnt",  squash_cnt,         16'(m_squash));
        chk("exec_cnt2",   16'(exec_cnt2),     16'(m_exec2));
        chk("squash_cnt2", 16'(squash_cnt2),   16'(m_squash2));
`endif
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        m_flags  = 4'h0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        cond     = 4'h0;
        ALUflags = 4'h0;
        flagW    = 2'b00;
        PCS      = 1'b0;
        RegW     = 1'b0;
        MemW     = 1'b0;
        NoWrite  = 1'b0;
`ifdef COND_STATS_EN
        m_exec = 0; m_squash = 0; m_exec2 = 0; m_squash2 = 0;
`endif

        // Reset held two cycles while an instruction is presented.
        step(1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_flags_const", 16'(flags), 16'h0);
        rst_n = 1'b1;

        // CMP then BEQ.
        step(1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("cmp_regwrite", 16'(RegWrite), 16'h0);
        chk("cmp_flags", 16'(flags), 16'h4);
        step(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq_pcsrc", 16'(PCSrc), 16'h1);

        // Squashed NE with flagW=11: no enables, flags hold.
        step(1'b1, 4'h1, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("squash_flags", 16'(flags), 16'h4);
        chk("squash_memw", 16'(MemWrite), 16'h0);

        // Partial writes.
        step(1'b1, 4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hE, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("partial_nz", 16'(flags), 16'hC);
        step(1'b1, 4'hE, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("partial_cv", 16'(flags), 16'hF);

        // Sweep all condition codes against all flag values, with gaps.
        for (int f = 0; f < 16; f++) begin
            step(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
            for (int c = 0; c < 16; c++) begin
                step(1'b1, 4'(c), 4'(~f), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end

        // Mid-stream reset drops the in-flight instruction.
        rst_n = 1'b0;
        step(1'b1, 4'hE, 4'h9, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;

`ifdef COND_STATS_EN
        // 3 executed, 2 squashed (flags are 0 so EQ fails).
        for (int i = 0; i < 3; i++) step(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stats_exec3", exec_cnt, 16'd3);
        chk("stats_squash2", squash_cnt, 16'd2);
        for (int i = 0; i < 5; i++) step(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stats_sat", 16'(exec_cnt2), 16'd3);
`endif

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
